// File: rtl/pinwheel_serial_pkg.sv
// Shared constants for the pinwheel_serial block: register offsets, STATUS/CTRL bit positions
// and the value returned by a DATA read of an empty RX FIFO.
package pinwheel_serial_pkg;
    localparam logic [1:0]  REG_DATA   = 2'd0;
    localparam logic [1:0]  REG_STATUS = 2'd1;
    localparam logic [1:0]  REG_CTRL   = 2'd2;

    localparam int ST_TX_FULL  = 16;
    localparam int ST_RX_EMPTY = 17;
    localparam int ST_TX_OVF   = 18;
    localparam int ST_RX_RDERR = 19;

    localparam int CTRL_RX_IRQ_EN = 0;
    localparam int CTRL_TX_IRQ_EN = 1;
    localparam int CTRL_CLEAR     = 8;

    localparam logic [31:0] EMPTY_READ = 32'h8000_0000;
endpackage

// File: rtl/pinwheel_fifo.sv
// Synchronous FIFO with registered count; a push into a full FIFO succeeds only when
// a pop happens in the same cycle.
module pinwheel_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                   clock,
    input  logic                   reset_in,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       din,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count,
    output logic [WIDTH-1:0]       head
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == FULL_COUNT);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clock) begin
        if (reset_in) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr] <= din;
    end
endmodule

// File: rtl/pinwheel_serial.sv
// Multi-channel memory-mapped serial block: per-channel TX/RX byte FIFOs behind a 1-cycle bus.
// Optional interrupt logic is built when PINWHEEL_SERIAL_IRQ_EN is defined.
module pinwheel_serial
    import pinwheel_serial_pkg::*;
#(
    parameter int          NUM_CHANNELS = 4,
    parameter int          FIFO_DEPTH   = 16,
    parameter logic [3:0]  BUS_TAG      = 4'hC
) (
    input  logic                      clock,
    input  logic                      reset_in,
    input  logic [31:0]               bus_addr,
    input  logic                      bus_rden,
    input  logic                      bus_wren,
    input  logic [31:0]               bus_wdata,
    input  logic [3:0]                bus_wmask,
    output logic                      bus_cs_out,
    output logic [31:0]               bus_rdata,
    output logic [NUM_CHANNELS-1:0]   tx_valid,
    output logic [8*NUM_CHANNELS-1:0] tx_data,
    input  logic [NUM_CHANNELS-1:0]   tx_ready,
    input  logic [NUM_CHANNELS-1:0]   rx_valid,
    input  logic [8*NUM_CHANNELS-1:0] rx_data,
    output logic [NUM_CHANNELS-1:0]   rx_ready,
    output logic                      irq
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic        sel;
    logic        ch_ok;
    logic        rd_acc;
    logic        wr_acc;
    logic [2:0]  ch;
    logic [1:0]  rsel;
    logic [31:0] rd_word;

    // Per-channel views padded to 8 entries so the 3-bit channel field indexes them directly.
    logic [7:0] tx_cnt  [8];
    logic [7:0] rx_cnt  [8];
    logic [7:0] rx_head [8];
    logic [7:0] tx_full;
    logic [7:0] rx_empty;
    logic [7:0] tx_ovf;
    logic [7:0] rx_rderr;
    logic [7:0] rx_irq_en;
    logic [7:0] tx_irq_en;
`ifdef PINWHEEL_SERIAL_IRQ_EN
    logic [7:0] irq_term;
`endif

    logic unused_bits;
    assign unused_bits = ^{bus_addr[27:7], bus_addr[1:0], bus_wdata[31:9], bus_wmask[3:2]};

    assign sel    = (bus_addr[31:28] == BUS_TAG);
    assign ch     = bus_addr[6:4];
    assign rsel   = bus_addr[3:2];
    assign ch_ok  = (int'(ch) < NUM_CHANNELS);
    assign rd_acc = bus_rden && sel && ch_ok;
    assign wr_acc = bus_wren && sel && ch_ok;

    for (genvar c = 0; c < 8; c++) begin : g_ch
        if (c < NUM_CHANNELS) begin : g_on
            logic          tx_push, rx_push, rx_pop, ctrl_wr, clr;
            logic          tx_empty, rx_full;
            logic          ovf, rderr;
            logic [CW-1:0] tx_c, rx_c;

            assign ctrl_wr = wr_acc && (ch == 3'(c)) && (rsel == REG_CTRL);
            assign clr     = ctrl_wr && bus_wmask[1] && bus_wdata[CTRL_CLEAR];
            assign tx_push = wr_acc && (ch == 3'(c)) && (rsel == REG_DATA) && bus_wmask[0];
            assign rx_pop  = rd_acc && (ch == 3'(c)) && (rsel == REG_DATA);
            assign rx_push = rx_valid[c] && rx_ready[c];

            pinwheel_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx (
                .clock(clock), .reset_in(reset_in), .push(tx_push), .pop(tx_ready[c]),
                .din(bus_wdata[7:0]), .full(tx_full[c]), .empty(tx_empty), .count(tx_c),
                .head(tx_data[8*c +: 8])
            );
            pinwheel_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx (
                .clock(clock), .reset_in(reset_in), .push(rx_push), .pop(rx_pop),
                .din(rx_data[8*c +: 8]), .full(rx_full), .empty(rx_empty[c]), .count(rx_c),
                .head(rx_head[c])
            );

            assign tx_valid[c] = !tx_empty;
            assign rx_ready[c] = !rx_full && !reset_in;
            assign tx_cnt[c]   = 8'(tx_c);
            assign rx_cnt[c]   = 8'(rx_c);
            assign tx_ovf[c]   = ovf;
            assign rx_rderr[c] = rderr;

            // A new error event in the same cycle as a clear leaves the flag set.
            always_ff @(posedge clock) begin
                if (reset_in) begin
                    ovf   <= 1'b0;
                    rderr <= 1'b0;
                end else begin
                    if (clr) begin
                        ovf   <= 1'b0;
                        rderr <= 1'b0;
                    end
                    if (tx_push && tx_full[c] && !tx_ready[c]) ovf <= 1'b1;
                    if (rx_pop && rx_empty[c])                 rderr <= 1'b1;
                end
            end

`ifdef PINWHEEL_SERIAL_IRQ_EN
            logic rx_en, tx_en;
            always_ff @(posedge clock) begin
                if (reset_in) begin
                    rx_en <= 1'b0;
                    tx_en <= 1'b0;
                end else if (ctrl_wr && bus_wmask[0]) begin
                    rx_en <= bus_wdata[CTRL_RX_IRQ_EN];
                    tx_en <= bus_wdata[CTRL_TX_IRQ_EN];
                end
            end
            assign rx_irq_en[c] = rx_en;
            assign tx_irq_en[c] = tx_en;
            assign irq_term[c]  = (rx_en && !rx_empty[c]) || (tx_en && tx_empty);
`else
            assign rx_irq_en[c] = 1'b0;
            assign tx_irq_en[c] = 1'b0;
`endif
        end else begin : g_off
            assign tx_cnt[c]    = '0;
            assign rx_cnt[c]    = '0;
            assign rx_head[c]   = '0;
            assign tx_full[c]   = 1'b0;
            assign rx_empty[c]  = 1'b0;
            assign tx_ovf[c]    = 1'b0;
            assign rx_rderr[c]  = 1'b0;
            assign rx_irq_en[c] = 1'b0;
            assign tx_irq_en[c] = 1'b0;
`ifdef PINWHEEL_SERIAL_IRQ_EN
            assign irq_term[c]  = 1'b0;
`endif
        end
    end

    always_comb begin
        rd_word = '0;
        if (ch_ok) begin
            case (rsel)
                REG_DATA:   rd_word = rx_empty[ch] ? EMPTY_READ : {24'h0, rx_head[ch]};
                REG_STATUS: begin
                    rd_word[7:0]        = tx_cnt[ch];
                    rd_word[15:8]       = rx_cnt[ch];
                    rd_word[ST_TX_FULL]  = tx_full[ch];
                    rd_word[ST_RX_EMPTY] = rx_empty[ch];
                    rd_word[ST_TX_OVF]   = tx_ovf[ch];
                    rd_word[ST_RX_RDERR] = rx_rderr[ch];
                end
                REG_CTRL: begin
                    rd_word[CTRL_RX_IRQ_EN] = rx_irq_en[ch];
                    rd_word[CTRL_TX_IRQ_EN] = tx_irq_en[ch];
                end
                default:    rd_word = '0;
            endcase
        end
    end

    // Read data is registered; out-of-range channels still acknowledge with zero data.
    always_ff @(posedge clock) begin
        if (reset_in) begin
            bus_cs_out <= 1'b0;
            bus_rdata  <= '0;
        end else begin
            bus_cs_out <= bus_rden && sel;
            if (bus_rden && sel) bus_rdata <= rd_word;
        end
    end

`ifdef PINWHEEL_SERIAL_IRQ_EN
    always_ff @(posedge clock) begin
        if (reset_in) irq <= 1'b0;
        else          irq <= |irq_term;
    end
`else
    assign irq = 1'b0;
`endif
endmodule

// File: tb/tb_pinwheel_serial.sv
// Directed bench for pinwheel_serial with a queue-based reference model compared every cycle.
module tb_pinwheel_serial;
    localparam int         NCH   = 4;
    localparam int         DEPTH = 4;
    localparam logic [3:0] TAG   = 4'hC;

    logic               clock = 1'b0;
    logic               reset_in = 1'b1;
    logic [31:0]        bus_addr = '0;
    logic               bus_rden = 1'b0;
    logic               bus_wren = 1'b0;
    logic [31:0]        bus_wdata = '0;
    logic [3:0]         bus_wmask = '0;
    logic               bus_cs_out;
    logic [31:0]        bus_rdata;
    logic [NCH-1:0]     tx_valid;
    logic [8*NCH-1:0]   tx_data;
    logic [NCH-1:0]     tx_ready = '0;
    logic [NCH-1:0]     rx_valid = '0;
    logic [8*NCH-1:0]   rx_data = '0;
    logic [NCH-1:0]     rx_ready;
    logic               irq;

    int tests = 0;
    int fails = 0;

    always #5 clock = ~clock;

    pinwheel_serial #(.NUM_CHANNELS(NCH), .FIFO_DEPTH(DEPTH), .BUS_TAG(TAG)) dut (
        .clock(clock), .reset_in(reset_in), .bus_addr(bus_addr), .bus_rden(bus_rden),
        .bus_wren(bus_wren), .bus_wdata(bus_wdata), .bus_wmask(bus_wmask),
        .bus_cs_out(bus_cs_out), .bus_rdata(bus_rdata), .tx_valid(tx_valid),
        .tx_data(tx_data), .tx_ready(tx_ready), .rx_valid(rx_valid), .rx_data(rx_data),
        .rx_ready(rx_ready), .irq(irq)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: FIFOs as queues, state advanced on each rising edge.
    logic [7:0]  mtx [NCH][$];
    logic [7:0]  mrx [NCH][$];
    bit          m_ovf [NCH];
    bit          m_rderr [NCH];
    bit          m_rxen [NCH];
    bit          m_txen [NCH];
    bit          m_cs = 1'b0;
    bit          m_irq = 1'b0;
    bit          m_on = 1'b0;
    logic [31:0] m_rdata = '0;

    function automatic logic [31:0] model_read(input int ch, input int r);
        logic [31:0] w = '0;
        case (r)
            0: w = (mrx[ch].size() == 0) ? 32'h8000_0000 : {24'h0, mrx[ch][0]};
            1: begin
                w[7:0]  = 8'(mtx[ch].size());
                w[15:8] = 8'(mrx[ch].size());
                w[16]   = (mtx[ch].size() == DEPTH);
                w[17]   = (mrx[ch].size() == 0);
                w[18]   = m_ovf[ch];
                w[19]   = m_rderr[ch];
            end
            2: w = {30'h0, m_txen[ch], m_rxen[ch]};
            default: w = '0;
        endcase
        return w;
    endfunction

    initial begin
        forever begin
            @(posedge clock);
            if (reset_in) begin
                for (int c = 0; c < NCH; c++) begin
                    mtx[c].delete();
                    mrx[c].delete();
                    m_ovf[c] = 0; m_rderr[c] = 0; m_rxen[c] = 0; m_txen[c] = 0;
                end
                m_cs = 0; m_rdata = '0; m_irq = 0; m_on = 1;
            end else if (m_on) begin
                bit          hit;
                bit          ch_in;
                bit          nirq;
                int          ch;
                int          r;
                logic [31:0] word;
                hit   = (bus_addr[31:28] == TAG);
                ch    = int'(bus_addr[6:4]);
                r     = int'(bus_addr[3:2]);
                ch_in = (ch < NCH);
                nirq  = 0;
                word  = '0;
                for (int c = 0; c < NCH; c++)
                    if ((m_rxen[c] && mrx[c].size() > 0) || (m_txen[c] && mtx[c].size() == 0)) nirq = 1;
                if (bus_rden && hit && ch_in) word = model_read(ch, r);
                for (int c = 0; c < NCH; c++) begin
                    bit me;
                    bit tpop;
                    bit rpush;
                    me    = hit && ch_in && (ch == c);
                    tpop  = tx_ready[c] && (mtx[c].size() > 0);
                    rpush = rx_valid[c] && (mrx[c].size() < DEPTH);
                    if (bus_wren && me && r == 2) begin
                        if (bus_wmask[1] && bus_wdata[8]) begin m_ovf[c] = 0; m_rderr[c] = 0; end
`ifdef PINWHEEL_SERIAL_IRQ_EN
                        if (bus_wmask[0]) begin m_rxen[c] = bus_wdata[0]; m_txen[c] = bus_wdata[1]; end
`endif
                    end
                    if (tpop) void'(mtx[c].pop_front());
                    if (bus_wren && me && r == 0 && bus_wmask[0]) begin
                        if (mtx[c].size() < DEPTH) mtx[c].push_back(bus_wdata[7:0]);
                        else m_ovf[c] = 1;
                    end
                    if (bus_rden && me && r == 0) begin
                        if (mrx[c].size() > 0) void'(mrx[c].pop_front());
                        else m_rderr[c] = 1;
                    end
                    if (rpush) mrx[c].push_back(rx_data[8*c +: 8]);
                end
                m_cs = bus_rden && hit;
                if (m_cs) m_rdata = word;
`ifdef PINWHEEL_SERIAL_IRQ_EN
                m_irq = nirq;
`else
                m_irq = 0;
`endif
            end
        end
    end

    initial begin
        forever begin
            @(negedge clock);
            if (m_on) begin
                for (int c = 0; c < NCH; c++) begin
                    chk($sformatf("tx_valid[%0d]", c), 32'(tx_valid[c]), 32'(mtx[c].size() > 0));
                    if (mtx[c].size() > 0)
                        chk($sformatf("tx_data[%0d]", c), 32'(tx_data[8*c +: 8]), 32'(mtx[c][0]));
                    chk($sformatf("rx_ready[%0d]", c), 32'(rx_ready[c]),
                        32'(!reset_in && (mrx[c].size() < DEPTH)));
                end
                chk("cs", 32'(bus_cs_out), 32'(m_cs));
                if (m_cs) chk("rdata", bus_rdata, m_rdata);
                chk("irq", 32'(irq), 32'(m_irq));
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin @(posedge clock); #1; end
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        bus_addr = a; bus_wdata = d; bus_wmask = 4'hF; bus_wren = 1'b1;
        @(posedge clock); #1;
        bus_wren = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d);
        bus_addr = a; bus_rden = 1'b1;
        @(posedge clock); #1;
        bus_rden = 1'b0;
        d = bus_rdata;
    endtask

    logic [31:0] d;
    logic [31:0] exp_ctrl;

    initial begin
        reset_in = 1'b1;
        idle(2);
        chk("rst_tx_valid", 32'(tx_valid), 32'h0);
        chk("rst_rx_ready", 32'(rx_ready), 32'h0);
        chk("rst_cs", 32'(bus_cs_out), 32'h0);
        chk("rst_rdata", bus_rdata, 32'h0);
        chk("rst_irq", 32'(irq), 32'h0);
        reset_in = 1'b0;
        idle(1);
        chk("rx_ready_after_rst", 32'(rx_ready), 32'hF);

        // Two TX bytes on ch1, then drain
        wr(32'hC000_0010, 32'h41);
        wr(32'hC000_0010, 32'h42);
        chk("t1_tx_valid1", 32'(tx_valid[1]), 32'h1);
        chk("t1_tx_data1", 32'(tx_data[15:8]), 32'h41);
        rd(32'hC000_0014, d);
        chk("t1_status", d, 32'h0002_0002);
        tx_ready[1] = 1'b1;
        idle(1);
        chk("t1_second_byte", 32'(tx_data[15:8]), 32'h42);
        idle(1);
        chk("t1_drained", 32'(tx_valid[1]), 32'h0);
        tx_ready[1] = 1'b0;

        // Overflow ch0 and clear the sticky flag
        for (int i = 1; i <= 5; i++) wr(32'hC000_0000, 32'(i));
        rd(32'hC000_0004, d);
        chk("t2_status_full_ovf", d, 32'h0007_0004);
        chk("t2_head", 32'(tx_data[7:0]), 32'h01);
        wr(32'hC000_0008, 32'h100);
        rd(32'hC000_0004, d);
        chk("t2_status_cleared", d, 32'h0003_0004);
        tx_ready[0] = 1'b1;
        idle(5);
        tx_ready[0] = 1'b0;
        chk("t2_drained", 32'(tx_valid), 32'h0);

        // Single RX byte on ch2, then an empty read
        rx_data[23:16] = 8'h55; rx_valid[2] = 1'b1;
        idle(1);
        rx_valid[2] = 1'b0;
        rd(32'hC000_0020, d);
        chk("t3_rx_byte", d, 32'h0000_0055);
        rd(32'hC000_0020, d);
        chk("t3_empty_read", d, 32'h8000_0000);
        rd(32'hC000_0024, d);
        chk("t3_rderr", d, 32'h000A_0000);
        wr(32'hC000_0028, 32'h100);
        rd(32'hC000_0024, d);
        chk("t3_rderr_cleared", d, 32'h0002_0000);

        // Fill ch3 RX, then pop and push together
        for (int i = 0; i < 4; i++) begin
            rx_data[31:24] = 8'(8'hA0 + i); rx_valid[3] = 1'b1;
            idle(1);
        end
        rx_valid[3] = 1'b0;
        chk("t4_rx_full_ready", 32'(rx_ready[3]), 32'h0);
        rd(32'hC000_0030, d);
        chk("t4_pop_a0", d, 32'h0000_00A0);
        bus_addr = 32'hC000_0030; bus_rden = 1'b1;
        rx_data[31:24] = 8'hA4; rx_valid[3] = 1'b1;
        idle(1);
        bus_rden = 1'b0; rx_valid[3] = 1'b0;
        chk("t4_pop_a1", bus_rdata, 32'h0000_00A1);
        rd(32'hC000_0034, d);
        chk("t4_count_kept", d, 32'h0000_0300);
        rd(32'hC000_0030, d); chk("t4_pop_a2", d, 32'h0000_00A2);
        rd(32'hC000_0030, d); chk("t4_pop_a3", d, 32'h0000_00A3);
        rd(32'hC000_0030, d); chk("t4_pop_a4", d, 32'h0000_00A4);
        rd(32'hC000_0030, d); chk("t4_empty", d, 32'h8000_0000);
        wr(32'hC000_0038, 32'h100);

        // Out-of-range channel and foreign bus tag
        wr(32'hC000_0050, 32'h77);
        chk("t5_no_tx", 32'(tx_valid), 32'h0);
        rd(32'hC000_0050, d);
        chk("t5_rdata", d, 32'h0);
        chk("t5_cs", 32'(bus_cs_out), 32'h1);
        rd(32'h8000_0010, d);
        chk("t5_other_tag_cs", 32'(bus_cs_out), 32'h0);

        // Simultaneous read and write of CTRL returns the old value
        bus_addr = 32'hC000_0008; bus_wdata = 32'h3; bus_wmask = 4'hF;
        bus_rden = 1'b1; bus_wren = 1'b1;
        idle(1);
        bus_rden = 1'b0; bus_wren = 1'b0;
        chk("t6_rdwr_old", bus_rdata, 32'h0);
`ifdef PINWHEEL_SERIAL_IRQ_EN
        exp_ctrl = 32'h3;
`else
        exp_ctrl = 32'h0;
`endif
        rd(32'hC000_0008, d);
        chk("t6_ctrl", d, exp_ctrl);
        wr(32'hC000_0008, 32'h1);
        rx_data[7:0] = 8'h99; rx_valid[0] = 1'b1;
        idle(1);
        rx_valid[0] = 1'b0;
        chk("t6_irq_early", 32'(irq), 32'h0);
        idle(1);
        chk("t6_irq_set", 32'(irq), exp_ctrl & 32'h1);
        rd(32'hC000_0000, d);
        chk("t6_rx_byte", d, 32'h0000_0099);
        idle(1);
        chk("t6_irq_clear", 32'(irq), 32'h0);

        // Reset mid-stream with a read in the reset cycle
        wr(32'hC000_0010, 32'h11);
        wr(32'hC000_0010, 32'h12);
        rx_data[23:16] = 8'h66; rx_valid[2] = 1'b1;
        idle(1);
        rx_valid[2] = 1'b0;
        reset_in = 1'b1; bus_addr = 32'hC000_0024; bus_rden = 1'b1;
        idle(1);
        bus_rden = 1'b0;
        chk("t7_cs", 32'(bus_cs_out), 32'h0);
        chk("t7_rdata", bus_rdata, 32'h0);
        chk("t7_tx_flushed", 32'(tx_valid), 32'h0);
        chk("t7_rx_ready", 32'(rx_ready), 32'h0);
        chk("t7_irq", 32'(irq), 32'h0);
        reset_in = 1'b0;
        idle(1);
        rd(32'hC000_0024, d);
        chk("t7_rx_flushed", d, 32'h0002_0000);
        rd(32'hC000_0014, d);
        chk("t7_tx_status", d, 32'h0002_0000);
        rd(32'hC000_0008, d);
        chk("t7_ctrl_reset", d, 32'h0);
        idle(2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/pinwheel_serial.md
# pinwheel_serial

Parametrised multi-channel memory-mapped serial block for the pinwheel SoC. It replaces the single stubbed serial register and the four fixed simulation consoles with `NUM_CHANNELS` byte channels. Each channel has a TX FIFO drained over a valid/ready handshake and an RX FIFO filled over a valid/ready handshake. The block sits on the core data bus at bus tag `BUS_TAG` (addr[31:28]); the top level muxes `bus_rdata` into the core's bus read data when `bus_cs_out` is high.

## Interface
Parameters:
- `NUM_CHANNELS`, default 4: number of channels, legal range 1..8.
- `FIFO_DEPTH`, default 16: entries per FIFO; must be a power of 2 in the range 2..128.
- `BUS_TAG`, default 4'hC: value of addr[31:28] that selects this block.

Ports:
- `clock`  in  1  single clock for the whole block.
- `reset_in`  in  1  synchronous reset, active high.
- `bus_addr`  in  32  core bus address.
- `bus_rden`  in  1  read strobe.
- `bus_wren`  in  1  write strobe.
- `bus_wdata`  in  32  write data.
- `bus_wmask`  in  4  byte enables.
- `bus_cs_out`  out  1  registered; high the cycle after an accepted read to this block.
- `bus_rdata`  out  32  registered read data, valid when `bus_cs_out` is high.
- `tx_valid`  out  NUM_CHANNELS  per-channel TX byte available.
- `tx_data`  out  8*NUM_CHANNELS  TX byte for each channel; channel c occupies bits [8c+7:8c].
- `tx_ready`  in  NUM_CHANNELS  sink accepts the TX byte.
- `rx_valid`  in  NUM_CHANNELS  source offers an RX byte.
- `rx_data`  in  8*NUM_CHANNELS  RX byte for each channel.
- `rx_ready`  out  NUM_CHANNELS  RX FIFO can accept a byte.
- `irq`  out  1  registered interrupt request (see Configuration).

## Operation
- Select: the block is selected when addr[31:28]==BUS_TAG. Within the block, the channel is addr[6:4] and the register is addr[3:2].
- Registers per channel:
  - 0 DATA. A write pushes wdata[7:0] into the TX FIFO; it requires wmask[0]. A read pops the RX FIFO and returns {rx_empty, 23'b0, byte}.
  - 1 STATUS, read-only: [7:0] tx_count, [15:8] rx_count, 16 tx_full, 17 rx_empty, 18 tx_ovf, 19 rx_rderr.
  - 2 CTRL: bit0 rx_irq_en, bit1 tx_irq_en. Writing 1 to bit 8 clears tx_ovf and rx_rderr; that bit reads 0.
  - 3 reserved: reads 0, writes ignored.
- Channel index >= NUM_CHANNELS: writes are ignored, reads return 0, `bus_cs_out` is still asserted.
- TX write when the FIFO is full: the byte is dropped and tx_ovf is set (sticky). If a pop happens in the same cycle, the write succeeds and the count is unchanged.
- DATA read when RX is empty: no pop; returns 32'h8000_0000; sets rx_rderr (sticky).
- TX drain: a transfer occurs when tx_valid && tx_ready. tx_valid = !tx_empty. tx_data = FIFO head.
- RX fill: a transfer occurs when rx_valid && rx_ready. rx_ready = !rx_full && !reset_in. An RX push and a bus pop in the same cycle are both honoured.
- rden and wren asserted together to the same address: the write takes effect and the read returns pre-write state.
- Reset values: all FIFOs empty, tx_valid 0, rx_ready 0 during reset and 1 afterwards, all sticky flags 0, CTRL 0, bus_rdata 0, bus_cs_out 0, irq 0.

## Timing
- Read latency is 1 cycle: rden in cycle N gives bus_rdata/bus_cs_out in cycle N+1, matching block_ram. The RX pop commits at the end of cycle N.
- A DATA write in cycle N makes tx_valid high in cycle N+1.
- An RX accept in cycle N makes rx_count visible to a STATUS read issued in cycle N+1, with data returned in cycle N+2.
- tx_full and rx_full are derived from registered counts; there is no combinational path from tx_ready/rx_valid to any output.
- FIFO pointers wrap modulo FIFO_DEPTH. Counts are log2(FIFO_DEPTH)+1 bits wide, zero-extended into the 8-bit STATUS fields.
- Reset asserted mid-operation flushes all FIFOs in that cycle. A read issued in the reset cycle returns 0 with bus_cs_out 0.

## Configuration
- `PINWHEEL_SERIAL_IRQ_EN` defined:
  - CTRL enables are implemented.
  - irq is registered as the OR over channels of (rx_irq_en && !rx_empty) || (tx_irq_en && tx_empty).
  - irq updates 1 cycle after the FIFO state changes.
- `PINWHEEL_SERIAL_IRQ_EN` undefined:
  - irq is tied to 0.
  - CTRL bits 0 and 1 read 0 and are not stored.
  - CTRL bit 8 (clear sticky flags) remains functional.

## Structure
- Package `pinwheel_serial_pkg` holds:
  - register offset constants `REG_DATA`, `REG_STATUS`, `REG_CTRL`;
  - STATUS bit-position constants;
  - the CTRL clear bit;
  - the empty-read value 32'h8000_0000.
- Sub-module `pinwheel_fifo`: synchronous FIFO with parameters WIDTH and DEPTH. It provides push/pop, full/empty, count and head outputs, and supports simultaneous push+pop when full. It is instantiated 2*NUM_CHANNELS times.
- The top of the block holds the address decode, read mux/register, CTRL/sticky registers and irq.

## Test plan
- Reset, then write 0x41, 0x42 to ch1 DATA (addr 0xC000_0010) with tx_ready=0: tx_valid[1]=1, tx_data=0x41, STATUS.tx_count=2. Raise tx_ready: 0x41 then 0x42 drain on consecutive cycles, then tx_valid[1]=0.
- FIFO_DEPTH=4: five writes to ch0 with tx_ready=0: tx_count=4, tx_full=1, tx_ovf=1. Write CTRL 0x100: tx_ovf=0.
- Drive rx_valid[2] with 0x55: a read of ch2 DATA in the next cycle returns 0x0000_0055 one cycle later. A second read returns 0x8000_0000 and sets rx_rderr.
- Fill ch3 RX to full: rx_ready[3]=0. Pop and push in the same cycle: rx_count is unchanged and byte order is preserved.
- Read and write ch5 with NUM_CHANNELS=4: rdata=0, bus_cs_out=1, no state change. A read with addr tag 0x8: bus_cs_out=0.
- With `PINWHEEL_SERIAL_IRQ_EN`: set ch0 rx_irq_en and push an RX byte, giving irq=1 two cycles after rx_valid. Pop the byte and irq returns to 0. Assert reset mid-stream: all FIFOs flush and irq=0.
